// File: rtl/bram_rmw_bridge.sv
// Request/grant front end for a single-port block RAM with one-cycle read latency.
// Partial writes become a RAM read followed by a merged write; responses stay in order.
module bram_rmw_bridge #(
  parameter  int DATA_W    = 32,
  parameter  int RAM_DEPTH = 1024,
  parameter  int ADDR_W    = 32,
  localparam int NB        = DATA_W / 8,
  localparam int OFF       = $clog2(NB),
  localparam int RA_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [NB-1:0]     be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              ram_cs,
  output logic [RA_W-1:0]   ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, RESP, MERGE} state_t;
  typedef enum logic [1:0] {RT_WRITE, RT_READ, RT_ERR} rtype_t;

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(RAM_DEPTH);

  state_t              state_q, state_d;
  rtype_t              rtype_q, rtype_d;
  logic [RA_W-1:0]     idx_q, idx_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [ADDR_W-1:0]   word_idx;
  logic                idx_err;
  logic                accept;
  logic                be_full;
  logic                be_null;
  logic [DATA_W-1:0]   merged;

  assign word_idx = addr_i >> OFF;
  assign idx_err  = (word_idx >= DEPTH_L);
  assign be_full  = (be_i == {NB{1'b1}});
  assign be_null  = (be_i == {NB{1'b0}});
  // rstn gates the grant so nothing is accepted while reset is held
  assign accept   = req_i & rstn & (state_q != MERGE);
  assign gnt_o    = accept;

  // Merge captured write bytes over the word returned by the RMW read
  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign merged[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : ram_dout[8*gi +: 8];
  end

  assign rvalid_o = (state_q == RESP);
  assign err_o    = rvalid_o & (rtype_q == RT_ERR);
  assign rdata_o  = (rvalid_o && rtype_q == RT_READ) ? ram_dout : '0;

  always_comb begin
    state_d  = state_q;
    rtype_d  = rtype_q;
    idx_d    = idx_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = idx_q;
    ram_din  = wdata_q;

    if (state_q == MERGE) begin
      ram_cs  = 1'b1;
      ram_we  = 1'b1;
      ram_din = merged;
      state_d = RESP;
      rtype_d = RT_WRITE;
    end else if (accept) begin
      state_d  = RESP;
      ram_addr = word_idx[RA_W-1:0];
      if (idx_err) begin
        rtype_d = RT_ERR;
      end else if (!we_i) begin
        ram_cs  = 1'b1;
        rtype_d = RT_READ;
      end else if (be_full) begin
        ram_cs  = 1'b1;
        ram_we  = 1'b1;
        ram_din = wdata_i;
        rtype_d = RT_WRITE;
      end else if (be_null) begin
        rtype_d = RT_WRITE;
      end else begin
        // read half of the RMW; the write half follows in MERGE
        ram_cs  = 1'b1;
        idx_d   = word_idx[RA_W-1:0];
        be_d    = be_i;
        wdata_d = wdata_i;
        state_d = MERGE;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rtype_q <= RT_WRITE;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rtype_q <= rtype_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_bram_rmw_bridge.sv
// Randomized bench for bram_rmw_bridge with a behavioural RAM and a word-level
// reference model that predicts grants, RAM activity and in-order responses.
module tb_bram_rmw_bridge;
  localparam int DATA_W    = 32;
  localparam int RAM_DEPTH = 1000;
  localparam int ADDR_W    = 32;
  localparam int NB        = DATA_W / 8;
  localparam int RA_W      = $clog2(RAM_DEPTH);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_i = 1'b0;
  logic              we_i = 1'b0;
  logic [NB-1:0]     be_i = '0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] wdata_i = '0;
  logic              gnt_o, rvalid_o, err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              ram_cs, ram_we;
  logic [RA_W-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;

  always #5 clk = ~clk;

  bram_rmw_bridge #(.DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .ram_cs(ram_cs), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM: one-cycle read latency, read register held between reads
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  resp_t             resp_q[$];
  logic [DATA_W-1:0] ref_mem [RAM_DEPTH];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  bit                prev_partial = 0;
  int                pidx = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One bus cycle: drive a request, check everything the model predicts, update the model.
  task automatic step(input bit req, input bit we, input logic [NB-1:0] be,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    logic [ADDR_W-1:0] idx;
    bit err, acc, nullw, fullw, part;
    resp_t r;
    req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    @(negedge clk);
    idx   = addr / NB;
    err   = (idx >= RAM_DEPTH);
    acc   = req && !prev_partial;
    nullw = we && (be == 0);
    fullw = we && (be == {NB{1'b1}});
    part  = we && !nullw && !fullw;
    chk("gnt", gnt_o, acc);
    if (prev_partial) begin
      chk("merge_cs", ram_cs, 1);
      chk("merge_we", ram_we, 1);
      chk("merge_addr", ram_addr, pidx[RA_W-1:0]);
      chk("merge_din", ram_din, ref_mem[pidx]);
    end else if (acc && !err && !nullw) begin
      chk("cs", ram_cs, 1);
      chk("we", ram_we, fullw);
      chk("addr", ram_addr, idx[RA_W-1:0]);
    end else begin
      chk("idle_cs", ram_cs, 0);
    end
    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      chk("rvalid", rvalid_o, 1);
      chk("rdata", rdata_o, resp_q[0].data);
      chk("err", err_o, resp_q[0].err);
      $display("cyc %0d rsp rdata=%h err=%0d", cyc, rdata_o, err_o);
      void'(resp_q.pop_front());
    end else begin
      chk("rvalid_idle", rvalid_o, 0);
    end
    prev_partial = 0;
    if (acc) begin
      r.cyc = cyc + 1; r.data = '0; r.err = 1'b0;
      if (err) begin
        r.err = 1'b1;
      end else if (!we) begin
        r.data = ref_mem[idx];
      end else begin
        for (int b = 0; b < NB; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        if (part) begin
          r.cyc = cyc + 2;
          prev_partial = 1;
          pidx = int'(idx);
        end
      end
      resp_q.push_back(r);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [DATA_W-1:0] saved;
    logic [ADDR_W-1:0] a;
    logic [NB-1:0]     be;
    int                w, r;

    for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = '0;

    // Reset: request held high must not be granted, outputs quiet
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_we", ram_we, 0);
    req_i = 1'b0;
    rstn  = 1'b1;
    @(posedge clk); #1;

    // Known contents for every word the random phase may read
    for (int i = 0; i < 16; i++) step(1, 1, 4'hF, 32'(i * 4), $urandom());
    for (int i = 990; i < 1000; i++) step(1, 1, 4'hF, 32'(i * 4), $urandom());
    idle();

    // Full write then immediate read of the same word
    step(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    step(1, 0, 4'h0, 32'h10, '0);
    idle();

    // Partial write merge; request during MERGE is not granted
    step(1, 1, 4'hF, 32'h10, 32'h11223344);
    step(1, 1, 4'b0101, 32'h10, 32'hAABBCCDD);
    step(1, 0, 4'h0, 32'h10, '0);
    step(1, 0, 4'h0, 32'h10, '0);
    idle();
    chk("ram_word4", mem[4], 32'h11BB33DD);

    // Eight back-to-back reads
    for (int i = 0; i < 8; i++) step(1, 0, 4'h0, 32'(i * 4), '0);
    idle();

    // Out-of-range read, null write, last valid word
    step(1, 0, 4'h0, 32'd4000, '0);
    step(1, 1, 4'h0, 32'h20, 32'h12345678);
    step(1, 0, 4'h0, 32'd3996, '0);
    idle();

    // Reset pulsed during MERGE abandons the write and its response
    saved = ref_mem[5];
    step(1, 1, 4'b0011, 32'd20, 32'hCAFEF00D);
    req_i = 1'b0;
    rstn  = 1'b0;
    #1;
    chk("mrst_cs", ram_cs, 0);
    chk("mrst_rvalid", rvalid_o, 0);
    rstn = 1'b1;
    ref_mem[5] = saved;
    resp_q.delete();
    prev_partial = 0;
    @(posedge clk); #1;
    cyc++;
    idle();
    step(1, 0, 4'h0, 32'd20, '0);
    idle();
    chk("mrst_word5", mem[5], saved);

    // Read followed immediately by a partial write to the same word
    step(1, 1, 4'hF, 32'd8, 32'h01020304);
    step(1, 0, 4'h0, 32'd8, '0);
    step(1, 1, 4'b1000, 32'd8, 32'h77000000);
    idle();
    step(1, 0, 4'h0, 32'd8, '0);
    idle();
    chk("ram_word2", mem[2], 32'h77020304);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 15);
      else if (r < 8) w = $urandom_range(990, 999);
      else            w = $urandom_range(1000, 1010);
      a = (32'(w) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = $urandom() | 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       be = '0;
        1:       be = '1;
        default: be = 4'($urandom());
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, be, a, $urandom());
    end
    repeat (3) idle();
    chk("drain", 32'(resp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
